mac_arbiter: RTL and testbench
==============================

MAC_ARBITER -- requirements
Module: mac_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters, range 2..8.
REQ-002 Parameter W, default 8: operand and result width in bits.
REQ-003 Port clk  input  1: single clock; all state updates on its rising edge.
REQ-004 Port rst  input  1: asynchronous, active-high reset.
REQ-005 Port hold  input  1: while high, no new grants are issued; in-flight operations still complete.
REQ-006 Port req_valid  input  N_REQ: requester i presents an operation.
REQ-007 Port req_a, req_b, req_c  input  N_REQ x W each: operands of requester i.
REQ-008 Port req_ready  output  N_REQ: one-hot-or-zero grant; transfer on req_valid[i] && req_ready[i].
REQ-009 Port resp_valid  output  1: resp_data, resp_id and resp_ovf are valid this cycle.
REQ-010 Port resp_id  output  clog2(N_REQ): index of the requester the result belongs to.
REQ-011 Port resp_data  output  W: (A*B + C) mod 2^W.
REQ-012 Port resp_ovf  output  1: exact A*B + C >= 2^W.

Function
REQ-013 req_ready shall be combinational from req_valid, hold and the priority pointer, with at most one bit set.
REQ-014 Arbitration shall be round-robin: search starts at (last_grant+1) mod N_REQ and wraps; the first requester with req_valid set is granted.
REQ-015 The pointer last_grant shall update only on a completed transfer; an idle cycle or a hold cycle leaves it unchanged.
REQ-016 hold=1 shall force req_ready to all zeros in the same cycle.
REQ-017 A requester shall keep req_valid and its operands stable until transfer; the block accepts at most one operation per cycle.
REQ-018 Latency: a transfer in cycle T shall produce resp_valid=1 in cycle T+2 with the matching resp_id, fixed and independent of load.
REQ-019 Throughput: one result per cycle under back-to-back grants; there is no response back-pressure.
REQ-020 Stage 1 shall register the full-width value A*B + C (2W+1 bits) together with valid and id; stage 2 shall register the truncated W LSBs, the overflow flag, valid and id.
REQ-021 When resp_valid=0, resp_data, resp_id and resp_ovf shall hold their last values.
REQ-022 With a single active requester, that requester shall be granted every cycle (no forced idle).

Reset
REQ-023 While rst=1: req_ready=0, resp_valid=0, resp_data=0, resp_id=0, resp_ovf=0, both stage valids=0, and last_grant=N_REQ-1 so that requester 0 has first priority.
REQ-024 Reset asserted mid-operation shall discard all in-flight results; no resp_valid pulse for them after reset release.
REQ-025 The first grant is possible in the first cycle after rst deasserts.

Structure
REQ-026 Shared package mac_pkg: W and N_REQ defaults, ID_W=clog2(N_REQ), and a typedef for the stage record (valid, id, value).
REQ-027 Sub-module mac_pipe: the 2-stage multiply-add with valid/id sideband; mac_arbiter contains the round-robin grant logic and the operand mux.

Verification
REQ-028 Reset, then only req 2 valid with A=3, B=4, C=5 -> req_ready=0100 same cycle; two cycles later resp_valid=1, resp_id=2, resp_data=17, resp_ovf=0.
REQ-029 All four requesters valid continuously from reset -> grant order 0,1,2,3,0,1; responses every cycle with ids in the same order, each delayed 2 cycles.
REQ-030 A=200, B=2, C=100 (W=8) -> resp_data=244 (500 mod 256), resp_ovf=1; A=255, B=255, C=255 -> resp_data=0, resp_ovf=1.
REQ-031 Requesters 1 and 3 valid, hold=1 for 3 cycles then 0 -> no req_ready during hold; after release, req 1 is granted then req 3; in-flight results from before the hold still appear on time.
REQ-032 Grant req 0 and req 1 in consecutive cycles, assert rst in the next cycle -> no resp_valid for either; all outputs 0; after release, req 0 has priority.
REQ-033 Last grant to req 3, then only req 0 and req 3 valid -> req 0 granted (wrap-around), then req 3.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared defaults, identifier width and pipeline record for the multiply-add arbiter.
package mac_pkg;

  localparam int DEF_W     = 8;
  localparam int DEF_N_REQ = 4;
  localparam int ID_W      = $clog2(DEF_N_REQ);

  // Stage-1 record at default widths: full-precision A*B + C plus sideband.
  typedef struct packed {
    logic              vld;
    logic [ID_W-1:0]   id;
    logic [2*DEF_W:0]  val;
  } stage_t;

  function automatic int wrap_idx(input int base, input int off, input int n);
    return (base + off) % n;
  endfunction

endpackage

// File: rtl/mac_pipe.sv
// Two-stage multiply-add: stage 1 holds exact A*B+C, stage 2 truncates and flags overflow.
// Latency 2 cycles, one result per cycle, no back-pressure; output fields hold while invalid.
module mac_pipe
  import mac_pkg::*;
#(
  parameter int W    = DEF_W,
  parameter int ID_W = mac_pkg::ID_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_vld_i,
  input  logic [ID_W-1:0] in_id_i,
  input  logic [W-1:0]    in_a_i,
  input  logic [W-1:0]    in_b_i,
  input  logic [W-1:0]    in_c_i,
  output logic            out_vld_o,
  output logic [ID_W-1:0] out_id_o,
  output logic [W-1:0]    out_data_o,
  output logic            out_ovf_o
);

  localparam int FW = 2*W + 1;

  typedef struct packed {
    logic            vld;
    logic [ID_W-1:0] id;
    logic [FW-1:0]   val;
  } s1_t;

  typedef struct packed {
    logic            vld;
    logic [ID_W-1:0] id;
    logic [W-1:0]    data;
    logic            ovf;
  } s2_t;

  s1_t s1_q, s1_d;
  s2_t s2_q, s2_d;

  always_comb begin
    s1_d     = s1_q;
    s1_d.vld = in_vld_i;
    if (in_vld_i) begin
      s1_d.id  = in_id_i;
      s1_d.val = FW'(in_a_i) * FW'(in_b_i) + FW'(in_c_i);
    end

    // Data fields only move with a valid record so the outputs keep their last result.
    s2_d     = s2_q;
    s2_d.vld = s1_q.vld;
    if (s1_q.vld) begin
      s2_d.id   = s1_q.id;
      s2_d.data = s1_q.val[W-1:0];
      s2_d.ovf  = |s1_q.val[FW-1:W];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign out_vld_o  = s2_q.vld;
  assign out_id_o   = s2_q.id;
  assign out_data_o = s2_q.data;
  assign out_ovf_o  = s2_q.ovf;

endmodule

// File: rtl/mac_arbiter.sv
// Round-robin arbiter feeding a 2-stage multiply-add; result appears 2 cycles after transfer.
// Grant is combinational and forced off by hold or reset; responses are never back-pressured.
module mac_arbiter
  import mac_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int W     = DEF_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        hold,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [N_REQ-1:0][W-1:0]     req_a,
  input  logic [N_REQ-1:0][W-1:0]     req_b,
  input  logic [N_REQ-1:0][W-1:0]     req_c,
  output logic [N_REQ-1:0]            req_ready,
  output logic                        resp_valid,
  output logic [$clog2(N_REQ)-1:0]    resp_id,
  output logic [W-1:0]                resp_data,
  output logic                        resp_ovf
);

  localparam int IW = $clog2(N_REQ);

  logic [IW-1:0] last_grant_q, last_grant_d;
  logic [IW-1:0] gnt_id;
  logic [IW-1:0] cand;
  logic          gnt_any;
  logic          xfer;
  logic [W-1:0]  op_a, op_b, op_c;

  // Search begins one past the previous winner and wraps, so every requester gets a turn.
  always_comb begin
    req_ready = '0;
    gnt_id    = '0;
    gnt_any   = 1'b0;
    cand      = '0;
    if (!rst && !hold) begin
      for (int k = 1; k <= N_REQ; k++) begin
        cand = IW'(wrap_idx(int'(last_grant_q), k, N_REQ));
        if (!gnt_any && req_valid[cand]) begin
          gnt_any = 1'b1;
          gnt_id  = cand;
        end
      end
      req_ready[gnt_id] = gnt_any;
    end
  end

  assign xfer         = |(req_valid & req_ready);
  assign last_grant_d = xfer ? gnt_id : last_grant_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= IW'(N_REQ - 1);
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

  assign op_a = req_a[gnt_id];
  assign op_b = req_b[gnt_id];
  assign op_c = req_c[gnt_id];

  mac_pipe #(
    .W    (W),
    .ID_W (IW)
  ) u_pipe (
    .clk        (clk),
    .rst        (rst),
    .in_vld_i   (xfer),
    .in_id_i    (gnt_id),
    .in_a_i     (op_a),
    .in_b_i     (op_b),
    .in_c_i     (op_c),
    .out_vld_o  (resp_valid),
    .out_id_o   (resp_id),
    .out_data_o (resp_data),
    .out_ovf_o  (resp_ovf)
  );

endmodule

// File: tb/tb_mac_arbiter.sv
// Bench for mac_arbiter: directed scenarios plus randomized traffic against a behavioural model.
module tb_mac_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic                clk = 1'b0;
  logic                rst;
  logic                hold;
  logic [N-1:0]        req_valid;
  logic [N-1:0][W-1:0] req_a, req_b, req_c;
  logic [N-1:0]        req_ready;
  logic                resp_valid;
  logic [1:0]          resp_id;
  logic [W-1:0]        resp_data;
  logic                resp_ovf;

  int n_chk  = 0;
  int n_pass = 0;

  // Behavioural model: pointer as an integer plus a two-deep delay line of expected results.
  int         m_last;
  logic       m_s1_vld, m_out_vld;
  logic [1:0] m_s1_id, m_out_id;
  logic [7:0] m_s1_data, m_out_data;
  logic       m_s1_ovf, m_out_ovf;
  logic       drop_on_grant;
  logic [15:0] got, exp;

  mac_arbiter #(.N_REQ(N), .W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .hold       (hold),
    .req_valid  (req_valid),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_c      (req_c),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_id    (resp_id),
    .resp_data  (resp_data),
    .resp_ovf   (resp_ovf)
  );

  always #5 clk = ~clk;

  function automatic logic [N-1:0] m_grant(input logic [N-1:0] v, input int last,
                                           input logic h, input logic r);
    logic [N-1:0] g;
    g = '0;
    if (r || h) return g;
    for (int k = 1; k <= N; k++) begin
      if (v[(last + k) % N]) begin
        g[(last + k) % N] = 1'b1;
        return g;
      end
    end
    return g;
  endfunction

  task automatic model_clear();
    m_last    = N - 1;
    m_s1_vld  = 1'b0; m_s1_id  = '0; m_s1_data  = '0; m_s1_ovf  = 1'b0;
    m_out_vld = 1'b0; m_out_id = '0; m_out_data = '0; m_out_ovf = 1'b0;
  endtask

  task automatic new_ops(input int i);
    req_a[i] = W'($urandom_range(0, 255));
    req_b[i] = W'($urandom_range(0, 255));
    req_c[i] = W'($urandom_range(0, 255));
  endtask

  // Advance one clock; the model consumes whatever the rules say was transferred.
  task automatic tick();
    logic [N-1:0] g;
    int full;
    g = m_grant(req_valid, m_last, hold, rst);
    @(posedge clk);
    if (rst) begin
      model_clear();
    end else begin
      if (m_s1_vld) begin
        m_out_id   = m_s1_id;
        m_out_data = m_s1_data;
        m_out_ovf  = m_s1_ovf;
      end
      m_out_vld = m_s1_vld;
      m_s1_vld  = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (g[i]) begin
          full      = int'(req_a[i]) * int'(req_b[i]) + int'(req_c[i]);
          m_s1_vld  = 1'b1;
          m_s1_id   = 2'(i);
          m_s1_data = 8'(full % 256);
          m_s1_ovf  = (full >= 256);
          m_last    = i;
        end
      end
    end
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      if (g[i]) begin
        new_ops(i);
        if (drop_on_grant) req_valid[i] = 1'b0;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_clear();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    req_valid = '1;
    for (int s = 0; s < 3; s++) begin
      #1;
      got = {req_ready, resp_valid, resp_id, resp_data, resp_ovf};
      n_chk++;
      if (got !== 16'h0) $display("FAIL reset step %0d: got %h, expected 0000", s, got);
      else n_pass++;
      tick();
    end
    req_valid = '0;
  endtask

  task automatic test_single();
    rst = 1'b0;
    drop_on_grant = 1'b1;
    req_valid = 4'b0100;
    req_a[2] = 8'd3; req_b[2] = 8'd4; req_c[2] = 8'd5;
    for (int s = 0; s < 4; s++) begin
      #1;
      exp = {m_grant(req_valid, m_last, hold, rst), m_out_vld, m_out_id, m_out_data, m_out_ovf};
      got = {req_ready, resp_valid, resp_id, resp_data, resp_ovf};
      n_chk++;
      if (got !== exp) $display("FAIL single step %0d: got %h, expected %h", s, got, exp);
      else n_pass++;
      if (s == 0) begin
        n_chk++;
        if (req_ready !== 4'b0100) $display("FAIL single_ready: got %b, expected 0100", req_ready);
        else n_pass++;
      end
      if (s == 2) begin
        n_chk++;
        if ({resp_valid, resp_id, resp_data, resp_ovf} !== {1'b1, 2'd2, 8'd17, 1'b0})
          $display("FAIL single_resp: got v%b id%0d d%0d o%b, expected v1 id2 d17 o0",
                   resp_valid, resp_id, resp_data, resp_ovf);
        else n_pass++;
      end
      tick();
    end
  endtask

  task automatic test_all_valid();
    do_reset();
    drop_on_grant = 1'b0;
    req_valid = '1;
    for (int s = 0; s < 8; s++) begin
      #1;
      exp = {m_grant(req_valid, m_last, hold, rst), m_out_vld, m_out_id, m_out_data, m_out_ovf};
      got = {req_ready, resp_valid, resp_id, resp_data, resp_ovf};
      n_chk++;
      if (got !== exp) $display("FAIL all_valid step %0d: got %h, expected %h", s, got, exp);
      else n_pass++;
      n_chk++;
      if (req_ready !== 4'(1 << (s % 4)))
        $display("FAIL all_order step %0d: got %b, expected grant %0d", s, req_ready, s % 4);
      else n_pass++;
      if (s >= 2) begin
        n_chk++;
        if (resp_valid !== 1'b1 || resp_id !== 2'((s - 2) % 4))
          $display("FAIL all_resp step %0d: got v%b id%0d, expected v1 id%0d",
                   s, resp_valid, resp_id, (s - 2) % 4);
        else n_pass++;
      end
      tick();
    end
    req_valid = '0;
    drop_on_grant = 1'b1;
  endtask

  task automatic test_overflow();
    drop_on_grant = 1'b1;
    for (int s = 0; s < 4; s++) begin
      if (s == 0) begin
        req_valid = 4'b0001; req_a[0] = 8'd200; req_b[0] = 8'd2; req_c[0] = 8'd100;
      end else if (s == 1) begin
        req_valid = 4'b0001; req_a[0] = 8'd255; req_b[0] = 8'd255; req_c[0] = 8'd255;
      end
      #1;
      exp = {m_grant(req_valid, m_last, hold, rst), m_out_vld, m_out_id, m_out_data, m_out_ovf};
      got = {req_ready, resp_valid, resp_id, resp_data, resp_ovf};
      n_chk++;
      if (got !== exp) $display("FAIL overflow step %0d: got %h, expected %h", s, got, exp);
      else n_pass++;
      if (s >= 2) begin
        n_chk++;
        if ({resp_valid, resp_data, resp_ovf} !== {1'b1, (s == 2) ? 8'd244 : 8'd0, 1'b1})
          $display("FAIL ovf_value step %0d: got v%b d%0d o%b, expected v1 d%0d o1",
                   s, resp_valid, resp_data, resp_ovf, (s == 2) ? 244 : 0);
        else n_pass++;
      end
      tick();
    end
  endtask

  task automatic test_hold();
    drop_on_grant = 1'b1;
    for (int s = 0; s < 7; s++) begin
      if (s == 0) begin
        req_valid = 4'b0001; hold = 1'b0;
      end else if (s == 1) begin
        req_valid = 4'b1010; hold = 1'b1;
      end else if (s == 4) begin
        hold = 1'b0;
      end
      #1;
      exp = {m_grant(req_valid, m_last, hold, rst), m_out_vld, m_out_id, m_out_data, m_out_ovf};
      got = {req_ready, resp_valid, resp_id, resp_data, resp_ovf};
      n_chk++;
      if (got !== exp) $display("FAIL hold step %0d: got %h, expected %h", s, got, exp);
      else n_pass++;
      if (s >= 1 && s <= 5) begin
        n_chk++;
        if (req_ready !== ((s <= 3) ? 4'b0000 : (s == 4) ? 4'b0010 : 4'b1000))
          $display("FAIL hold_ready step %0d: got %b", s, req_ready);
        else n_pass++;
      end
      if (s == 2) begin
        n_chk++;
        if (resp_valid !== 1'b1 || resp_id !== 2'd0)
          $display("FAIL hold_inflight: got v%b id%0d, expected v1 id0", resp_valid, resp_id);
        else n_pass++;
      end
      tick();
    end
  endtask

  task automatic test_midreset();
    do_reset();
    drop_on_grant = 1'b1;
    req_valid = 4'b0011;
    for (int s = 0; s < 7; s++) begin
      if (s == 2) begin
        rst = 1'b1;
        model_clear();
      end else if (s == 3) begin
        rst = 1'b0;
        req_valid = 4'b1111;
      end
      #1;
      exp = {m_grant(req_valid, m_last, hold, rst), m_out_vld, m_out_id, m_out_data, m_out_ovf};
      got = {req_ready, resp_valid, resp_id, resp_data, resp_ovf};
      n_chk++;
      if (got !== exp) $display("FAIL midreset step %0d: got %h, expected %h", s, got, exp);
      else n_pass++;
      if (s == 2) begin
        n_chk++;
        if (got !== 16'h0) $display("FAIL midreset_zero: got %h, expected 0000", got);
        else n_pass++;
      end
      if (s == 3 || s == 4) begin
        n_chk++;
        if (resp_valid !== 1'b0 || (s == 3 && req_ready !== 4'b0001))
          $display("FAIL midreset_after step %0d: got v%b ready %b", s, resp_valid, req_ready);
        else n_pass++;
      end
      tick();
    end
    req_valid = '0;
  endtask

  task automatic test_wrap();
    drop_on_grant = 1'b1;
    for (int s = 0; s < 3; s++) begin
      if (s == 0) req_valid = 4'b1000;
      else if (s == 1) req_valid = 4'b1001;
      #1;
      exp = {m_grant(req_valid, m_last, hold, rst), m_out_vld, m_out_id, m_out_data, m_out_ovf};
      got = {req_ready, resp_valid, resp_id, resp_data, resp_ovf};
      n_chk++;
      if (got !== exp) $display("FAIL wrap step %0d: got %h, expected %h", s, got, exp);
      else n_pass++;
      n_chk++;
      if (req_ready !== ((s == 1) ? 4'b0001 : 4'b1000))
        $display("FAIL wrap_grant step %0d: got %b", s, req_ready);
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_random();
    drop_on_grant = 1'b1;
    for (int s = 0; s < 400; s++) begin
      rst = ($urandom_range(0, 63) == 0);
      if (rst) model_clear();
      hold = ($urandom_range(0, 4) == 0);
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i]) begin
          new_ops(i);
          req_valid[i] = ($urandom_range(0, 1) == 1);
        end
      end
      #1;
      exp = {m_grant(req_valid, m_last, hold, rst), m_out_vld, m_out_id, m_out_data, m_out_ovf};
      got = {req_ready, resp_valid, resp_id, resp_data, resp_ovf};
      n_chk++;
      if (got !== exp) $display("FAIL random step %0d: got %h, expected %h", s, got, exp);
      else n_pass++;
      tick();
    end
    rst = 1'b0;
    hold = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    hold = 1'b0;
    req_valid = '0;
    req_a = '0; req_b = '0; req_c = '0;
    drop_on_grant = 1'b1;
    model_clear();
    test_reset();
    test_single();
    test_all_valid();
    test_overflow();
    test_hold();
    test_midreset();
    test_wrap();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
